debounce_sync: RTL and testbench

//  Input conditioner placed directly upstream of the D flip-flop stage.
//  It takes a raw asynchronous level (switch or external pin) and passes it through
//  an N-stage synchronizer, then filters glitches with a stability counter.

---
 rtl/debounce_sync_if.sv | 28 ++
 rtl/debounce_sync.sv | 63 ++++++
 tb/tb_debounce_sync.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/debounce_sync_if.sv
// Signal bundle between a debounce_sync conditioner and the logic that drives or consumes it.
// The "slave" modport is the debouncer's side; the "master" modport is the surrounding logic's side.
interface debounce_sync_if;
  logic i_din;
  logic i_en;
  logic o_dout;
  logic o_rise;
  logic o_fall;
  logic o_busy;

  modport master (
    output i_din,
    output i_en,
    input  o_dout,
    input  o_rise,
    input  o_fall,
    input  o_busy
  );

  modport slave (
    input  i_din,
    input  i_en,
    output o_dout,
    output o_rise,
    output o_fall,
    output o_busy
  );
endinterface

// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous level through a flop chain, then accepts a level change only
// after STABLE_CNT consecutive enabled cycles of disagreement; emits 1-cycle rise/fall strobes.
module debounce_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int STABLE_CNT  = 10
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  debounce_sync_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_dout;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  // The chain shifts on every clock regardless of the sample enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_dout) begin
        // Agreement drops any partial count, so short glitches vanish.
        r_cnt <= '0;
      end else if (bus.i_en) begin
        if (r_cnt == LP_CNT_LAST) begin
          r_dout <= w_s;
          r_cnt  <= '0;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.o_dout = r_dout;
  assign bus.o_rise = r_rise;
  assign bus.o_fall = r_fall;
  assign bus.o_busy = (r_cnt != '0);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: a default build and a STABLE_CNT=1/SYNC_STAGES=3 build,
// each checked every cycle against a delay-line/run-length model plus literal expectations.
module tb_debounce_sync;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  debounce_sync_if if0 ();
  debounce_sync_if if1 ();

  debounce_sync #(.SYNC_STAGES(2), .CNT_W(4), .STABLE_CNT(10)) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if0)
  );

  debounce_sync #(.SYNC_STAGES(3), .CNT_W(4), .STABLE_CNT(1)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Model: s is din delayed by the synchronizer depth; a change is accepted once the
  // number of enabled cycles with s != dout, uninterrupted by agreement, reaches the threshold.
  int        m_stages [2] = '{2, 3};
  int        m_thr    [2] = '{10, 1};
  logic [7:0] m_pipe  [2];
  int        m_run    [2];
  logic      m_dout   [2];
  logic      m_rise   [2];
  logic      m_fall   [2];

  task automatic model_step(input int k, input logic d, input logic e);
    logic s;
    s = m_pipe[k][m_stages[k]-1];
    m_rise[k] = 1'b0;
    m_fall[k] = 1'b0;
    if (s == m_dout[k]) begin
      m_run[k] = 0;
    end else if (e) begin
      m_run[k] = m_run[k] + 1;
      if (m_run[k] == m_thr[k]) begin
        m_dout[k] = s;
        m_rise[k] = s;
        m_fall[k] = ~s;
        m_run[k]  = 0;
      end
    end
    m_pipe[k] = {m_pipe[k][6:0], d};
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pipe[k] = '0;
        m_run[k]  = 0;
        m_dout[k] = 1'b0;
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
      end
    end else begin
      model_step(0, if0.i_din, if0.i_en);
      model_step(1, if1.i_din, if1.i_en);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m0.dout", if0.o_dout, m_dout[0]);
      chk("m0.rise", if0.o_rise, m_rise[0]);
      chk("m0.fall", if0.o_fall, m_fall[0]);
      chk("m0.busy", if0.o_busy, m_run[0] != 0);
      chk("m1.dout", if1.o_dout, m_dout[1]);
      chk("m1.rise", if1.o_rise, m_rise[1]);
      chk("m1.fall", if1.o_fall, m_fall[1]);
      chk("m1.busy", if1.o_busy, m_run[1] != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    if0.i_din = 1'b1;
    if0.i_en  = 1'b1;
    if1.i_din = 1'b0;
    if1.i_en  = 1'b1;

    // 1. Reset held with din=1, then release and measure latency.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.dout", if0.o_dout, 1'b0);
      chk("rst.rise", if0.o_rise, 1'b0);
      chk("rst.fall", if0.o_fall, 1'b0);
      chk("rst.busy", if0.o_busy, 1'b0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (e <= 11) chk("t1.dout_low", if0.o_dout, 1'b0);
      if (e == 12) begin
        chk("t1.dout_e12", if0.o_dout, 1'b1);
        chk("t1.rise_e12", if0.o_rise, 1'b1);
      end
      if (e == 13) chk("t1.rise_e13", if0.o_rise, 1'b0);
    end

    // 2. Clean fall.
    if0.i_din = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      tick();
      chk("t2.busy", if0.o_busy, (e >= 3 && e <= 11));
      chk("t2.fall", if0.o_fall, (e == 12));
      if (e == 12) chk("t2.dout_e12", if0.o_dout, 1'b0);
    end

    // 3. Five-clock glitch.
    if0.i_din = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 5) if0.i_din = 1'b0;
      chk("t3.dout", if0.o_dout, 1'b0);
      chk("t3.rise", if0.o_rise, 1'b0);
      if (e == 7) chk("t3.busy_e7", if0.o_busy, 1'b1);
      if (e == 8) chk("t3.busy_e8", if0.o_busy, 1'b0);
    end

    // 4. Enable 1-in-4, freeze for 20 clocks, then resume; 5 counts before and after freeze.
    if0.i_din = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if0.i_en = (i % 4 == 0);
      tick();
      chk("t4.dout_p1", if0.o_dout, 1'b0);
    end
    if0.i_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4.busy_frozen", if0.o_busy, 1'b1);
      chk("t4.dout_frozen", if0.o_dout, 1'b0);
    end
    for (int j = 0; j < 17; j++) begin
      if0.i_en = (j % 4 == 0);
      tick();
      if (j == 15) begin
        chk("t4.dout_pre", if0.o_dout, 1'b0);
        chk("t4.busy_pre", if0.o_busy, 1'b1);
      end
    end
    chk("t4.dout_acc", if0.o_dout, 1'b1);
    chk("t4.rise_acc", if0.o_rise, 1'b1);
    if0.i_en = 1'b1;
    tick();
    chk("t4.rise_end", if0.o_rise, 1'b0);

    // 5. Reset in the middle of a count.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) tick();
    chk("t5.busy_cnt7", if0.o_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.dout_rst", if0.o_dout, 1'b0);
    chk("t5.busy_rst", if0.o_busy, 1'b0);
    chk("t5.rise_rst", if0.o_rise, 1'b0);
    #2;
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 11) begin
        chk("t5.dout_e11", if0.o_dout, 1'b0);
        chk("t5.busy_e11", if0.o_busy, 1'b1);
      end
      if (e == 12) begin
        chk("t5.dout_e12", if0.o_dout, 1'b1);
        chk("t5.rise_e12", if0.o_rise, 1'b1);
      end
    end

    // 6. Short build: STABLE_CNT=1, SYNC_STAGES=3.
    if1.i_din = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("t6.busy", if1.o_busy, 1'b0);
      chk("t6.dout", if1.o_dout, (e >= 4));
      chk("t6.rise", if1.o_rise, (e == 4));
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
